// File: rtl/alu_if.sv
// Operand/result bundle between the execute-stage issue logic and the ALU.
// master drives operands and the operation code; slave returns the result and flags.
interface alu_if;
   localparam int unsigned XLEN = 32;
   localparam int unsigned OPW  = 4;

   logic            load_hazard;
   logic [XLEN-1:0] op_a;
   logic [XLEN-1:0] op_b;
   logic [OPW-1:0]  ALU_op;
   logic [XLEN-1:0] res;
   logic            mul_stall;
   logic            z;
   logic            less;

   modport master (
      output load_hazard, op_a, op_b, ALU_op,
      input  res, mul_stall, z, less
   );

   modport slave (
      input  load_hazard, op_a, op_b, ALU_op,
      output res, mul_stall, z, less
   );
endinterface

// File: rtl/alu.sv
// Execute-stage ALU: combinational RV32I operations, a registered RV32M multiplier
// that stalls the pipeline for one cycle per multiply, and branch compare flags.
module alu (
   input  logic CLK,
   input  logic nrst,
   alu_if.slave bus
);
   localparam int unsigned XLEN = 32;
   localparam int unsigned PW   = 2 * XLEN;
   localparam int unsigned SHW  = 5;

   typedef enum logic [3:0] {
      OP_NOP0   = 4'd0,
      OP_ADD    = 4'd1,
      OP_SUB    = 4'd2,
      OP_AND    = 4'd3,
      OP_OR     = 4'd4,
      OP_XOR    = 4'd5,
      OP_SLT    = 4'd6,
      OP_SLTU   = 4'd7,
      OP_SLL    = 4'd8,
      OP_SRL    = 4'd9,
      OP_SRA    = 4'd10,
      OP_MUL    = 4'd11,
      OP_MULH   = 4'd12,
      OP_MULHSU = 4'd13,
      OP_MULHU  = 4'd14,
      OP_NOP15  = 4'd15
   } op_e;

   op_e                    op;
   logic [SHW-1:0]         shamt;
   logic                   lt_s;
   logic                   lt_u;
   logic                   is_mul;
   logic                   sign_a;
   logic                   sign_b;
   logic signed [PW-1:0]   mul_a;
   logic signed [PW-1:0]   mul_b;
   logic [PW-1:0]          product;
   logic [PW-1:0]          prod;
   logic                   done;
   logic [XLEN-1:0]        res_c;

   assign op     = op_e'(bus.ALU_op);
   assign shamt  = bus.op_b[SHW-1:0];
   assign lt_s   = $signed(bus.op_a) < $signed(bus.op_b);
   assign lt_u   = bus.op_a < bus.op_b;
   assign is_mul = (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU);

   // Operand signedness: A is signed except for MULHU, B only for MUL/MULH.
   assign sign_a = (op != OP_MULHU);
   assign sign_b = (op == OP_MUL) || (op == OP_MULH);

   // Extending straight to 64 bits keeps the low 64 product bits identical to the
   // 33x33 -> 66-bit signed product, and those are the only bits ever consumed.
   assign mul_a   = {{XLEN{sign_a & bus.op_a[XLEN-1]}}, bus.op_a};
   assign mul_b   = {{XLEN{sign_b & bus.op_b[XLEN-1]}}, bus.op_b};
   assign product = PW'(mul_a * mul_b);

   // Multiplier result register; done marks a captured product for one cycle.
   always_ff @(posedge CLK or posedge nrst) begin
      if (nrst) begin
         prod <= '0;
         done <= 1'b0;
      end else if (bus.load_hazard) begin
         done <= 1'b0;
      end else if (is_mul && !done) begin
         prod <= product;
         done <= 1'b1;
      end else begin
         done <= 1'b0;
      end
   end

   // Result select.
   always_comb begin
      res_c = '0;
      unique case (op)
         OP_ADD:    res_c = bus.op_a + bus.op_b;
         OP_SUB:    res_c = bus.op_a - bus.op_b;
         OP_AND:    res_c = bus.op_a & bus.op_b;
         OP_OR:     res_c = bus.op_a | bus.op_b;
         OP_XOR:    res_c = bus.op_a ^ bus.op_b;
         OP_SLT:    res_c = XLEN'(lt_s);
         OP_SLTU:   res_c = XLEN'(lt_u);
         OP_SLL:    res_c = bus.op_a << shamt;
         OP_SRL:    res_c = bus.op_a >> shamt;
         OP_SRA:    res_c = XLEN'($signed(bus.op_a) >>> shamt);
         OP_MUL:    res_c = prod[XLEN-1:0];
         OP_MULH,
         OP_MULHSU,
         OP_MULHU:  res_c = prod[PW-1:XLEN];
         default:   res_c = '0;
      endcase
   end

   assign bus.res       = res_c;
   assign bus.mul_stall = is_mul && !done;
   assign bus.z         = (res_c == '0);
   // Branch compare: unsigned only when the issuing op is SLTU (BLTU/BGEU).
   assign bus.less      = (op == OP_SLTU) ? lt_u : lt_s;
endmodule

// File: tb/tb_alu.sv
// Directed-vector bench for alu: stimulus queues expected responses, a monitor
// samples on the falling edge and checks them against the DUT.
module tb_alu;
   localparam logic [3:0] NOP0 = 4'd0,  ADD = 4'd1,  SUB = 4'd2,  AND_ = 4'd3,
                          OR_ = 4'd4,  XOR_ = 4'd5, SLT = 4'd6,  SLTU = 4'd7,
                          SLL = 4'd8,  SRL = 4'd9,  SRA = 4'd10, MUL = 4'd11,
                          MULH = 4'd12, MULHSU = 4'd13, MULHU = 4'd14, NOP15 = 4'd15;

   localparam logic [31:0] A1 = 32'hC0E19800, B1 = 32'hEEE19000;
   localparam logic [31:0] A2 = 32'h80000000, B2 = 32'h0000003F;
   localparam logic [31:0] A3 = 32'h12345678, AF = 32'hFFFFFFFF;

   typedef struct {
      string       name;
      bit          cr;
      logic [31:0] r;
      int          s;
      int          zz;
      int          ll;
   } exp_t;

   logic  CLK;
   logic  nrst;
   alu_if bus ();

   exp_t  sb[$];
   int    passed = 0;
   int    total  = 0;

   alu dut (.CLK(CLK), .nrst(nrst), .bus(bus));

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act === exp) passed++;
      else $display("FAIL %s: got %h expected %h", nm, act, exp);
   endtask

   // Drive one cycle of inputs just after the edge and queue what must be seen.
   task automatic step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic lh, input logic rs, input string nm,
                       input bit cr, input logic [31:0] r, input int s, input int zz, input int ll);
      exp_t e;
      @(posedge CLK);
      #1;
      bus.ALU_op      = op;
      bus.op_a        = a;
      bus.op_b        = b;
      bus.load_hazard = lh;
      nrst            = rs;
      e.name = nm; e.cr = cr; e.r = r; e.s = s; e.zz = zz; e.ll = ll;
      sb.push_back(e);
   endtask

   // Monitor: compare every queued expectation against the settled outputs.
   initial begin
      exp_t e;
      forever begin
         @(negedge CLK);
         while (sb.size() > 0) begin
            e = sb.pop_front();
            if (e.cr)      check({e.name, " res"},   bus.res, e.r);
            if (e.s  >= 0) check({e.name, " stall"}, 32'(bus.mul_stall), 32'(e.s));
            if (e.zz >= 0) check({e.name, " z"},     32'(bus.z), 32'(e.zz));
            if (e.ll >= 0) check({e.name, " less"},  32'(bus.less), 32'(e.ll));
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      nrst            = 1'b1;
      bus.ALU_op      = MUL;
      bus.op_a        = A1;
      bus.op_b        = B1;
      bus.load_hazard = 1'b0;

      // Reset behaviour and first multiply after release.
      step(MUL, A1, B1, 0, 1, "rst_mul",  1, 32'h0, 1, 1, -1);
      step(MUL, A1, B1, 0, 0, "rel_mul",  0, 32'h0, 1, -1, -1);
      step(MUL, A1, B1, 0, 0, "mul_done", 1, 32'h7D800000, 0, 0, -1);

      // Combinational ops.
      step(ADD,   A1, B1, 0, 0, "add",   1, 32'hAFC32800, 0, 0, 1);
      step(SUB,   A1, B1, 0, 0, "sub",   1, 32'hD2000800, 0, 0, 1);
      step(AND_,  A1, B1, 0, 0, "and",   1, 32'hC0E19000, 0, 0, 1);
      step(OR_,   A1, B1, 0, 0, "or",    1, 32'hEEE19800, 0, 0, 1);
      step(XOR_,  A1, B1, 0, 0, "xor",   1, 32'h2E000800, 0, 0, 1);
      step(SLT,   A1, B1, 0, 0, "slt",   1, 32'h1, 0, 0, 1);
      step(SLTU,  A1, B1, 0, 0, "sltu",  1, 32'h1, 0, 0, 1);
      step(SLL,   A1, B1, 0, 0, "sll0",  1, 32'hC0E19800, 0, 0, 1);
      step(NOP0,  A1, B1, 0, 0, "nop0",  1, 32'h0, 0, 1, 1);
      step(NOP15, A1, B1, 0, 0, "nop15", 1, 32'h0, 0, 1, 1);

      // Load hazard holds the multiplier off.
      step(MUL, A1, B1, 1, 0, "mul_lh_a", 0, 32'h0, 1, -1, -1);
      step(MUL, A1, B1, 1, 0, "mul_lh_b", 0, 32'h0, 1, -1, -1);
      step(MUL, A1, B1, 0, 0, "mul_lh_c", 0, 32'h0, 1, -1, -1);
      step(MUL, A1, B1, 0, 0, "mul_res",  1, 32'h7D800000, 0, 0, -1);

      step(NOP0,   A1, B1, 0, 0, "gap1",        1, 32'h0, 0, 1, -1);
      step(MULH,   A1, B1, 0, 0, "mulh_stall",  0, 32'h0, 1, -1, -1);
      step(MULH,   A1, B1, 0, 0, "mulh",        1, 32'h04388615, 0, 0, -1);
      step(NOP0,   A1, B1, 0, 0, "gap2",        1, 32'h0, 0, 1, -1);
      step(MULHU,  A1, B1, 0, 0, "mulhu_stall", 0, 32'h0, 1, -1, -1);
      step(MULHU,  A1, B1, 0, 0, "mulhu",       1, 32'hB3FBAE15, 0, 0, -1);
      step(NOP0,   A1, B1, 0, 0, "gap3",        1, 32'h0, 0, 1, -1);
      step(MULHSU, A1, B1, 0, 0, "mulhsu_stall",0, 32'h0, 1, -1, -1);
      step(MULHSU, A1, B1, 0, 0, "mulhsu",      1, 32'hC51A1E15, 0, 0, -1);
      step(MULHSU, A1, B1, 0, 0, "b2b_stall",   0, 32'h0, 1, -1, -1);

      // Shift-by-31 and sign corners.
      step(SLL,  A2, B2, 0, 0, "sll31",  1, 32'h00000000, 0, 1, 1);
      step(SRL,  A2, B2, 0, 0, "srl31",  1, 32'h00000001, 0, 0, 1);
      step(SRA,  A2, B2, 0, 0, "sra31",  1, 32'hFFFFFFFF, 0, 0, 1);
      step(SLT,  A2, B2, 0, 0, "slt2",   1, 32'h1, 0, 0, 1);
      step(SLTU, A2, B2, 0, 0, "sltu2",  1, 32'h0, 0, 1, 0);
      step(SUB,  A3, A3, 0, 0, "sub_eq", 1, 32'h0, 0, 1, 0);

      // All-ones multiply corners.
      step(MULH,   AF, AF, 0, 0, "c_mulh_s",   0, 32'h0, 1, -1, -1);
      step(MULH,   AF, AF, 0, 0, "c_mulh",     1, 32'h00000000, 0, 1, -1);
      step(NOP0,   AF, AF, 0, 0, "gap4",       1, 32'h0, 0, 1, -1);
      step(MULHU,  AF, AF, 0, 0, "c_mulhu_s",  0, 32'h0, 1, -1, -1);
      step(MULHU,  AF, AF, 0, 0, "c_mulhu",    1, 32'hFFFFFFFE, 0, 0, -1);
      step(NOP0,   AF, AF, 0, 0, "gap5",       1, 32'h0, 0, 1, -1);
      step(MULHSU, AF, AF, 0, 0, "c_mulhsu_s", 0, 32'h0, 1, -1, -1);
      step(MULHSU, AF, AF, 0, 0, "c_mulhsu",   1, 32'hFFFFFFFF, 0, 0, -1);
      step(NOP0,   AF, AF, 0, 0, "gap6",       1, 32'h0, 0, 1, -1);
      step(MUL,    AF, AF, 0, 0, "c_mul_s",    0, 32'h0, 1, -1, -1);
      step(MUL,    AF, AF, 0, 0, "c_mul",      1, 32'h00000001, 0, 0, -1);

      // Reset in the middle of a multiply discards the product and restarts.
      step(NOP0, AF, AF, 0, 0, "gap7",        1, 32'h0, 0, 1, -1);
      step(MUL,  AF, AF, 0, 0, "abort_start", 0, 32'h0, 1, -1, -1);
      step(MUL,  AF, AF, 0, 1, "abort_rst",   1, 32'h0, 1, 1, -1);
      step(MUL,  AF, AF, 0, 0, "abort_rel",   0, 32'h0, 1, -1, -1);
      step(MUL,  AF, AF, 0, 0, "abort_res",   1, 32'h00000001, 0, 0, -1);

      repeat (2) @(posedge CLK);
      check("scoreboard_drained", 32'(sb.size()), 32'd0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule

// File: doc/alu.md
Name: alu

Overview:
- Execute-stage ALU of the pipelined RV32IMC core.
- Performs RV32I integer operations combinationally.
- Performs the four RV32M multiply operations (MUL, MULH, MULHSU, MULHU) through a registered multiplier stage, requesting a one-cycle pipeline stall via mul_stall.
- Also produces zero and less-than flags for branch resolution.

Parameters:
- none (opcodes fixed: ADD=1, SUB=2, AND=3, OR=4, XOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, MUL=11, MULH=12, MULHSU=13, MULHU=14; 0 and 15 are NOP)

Ports:
- CLK  input  1  system clock, rising edge.
- nrst  input  1  reset; asynchronous, active-high (despite the name).
- load_hazard  input  1  operands not yet valid (load-use bubble); multiplier must not capture.
- op_a  input  32  operand A (rs1).
- op_b  input  32  operand B (rs2/immediate).
- ALU_op  input  4  operation select, encodings above.
- res  output  32  result.
- mul_stall  output  1  high while a multiply result is not yet available.
- z  output  1  res equals zero.
- less  output  1  comparison flag.

Behaviour:
- Non-multiply ops are purely combinational; res is valid in the same cycle.
- ADD/SUB: wrap mod 2^32.
- AND/OR/XOR: bitwise.
- SLT: signed compare, result 32'd1/32'd0.
- SLTU: unsigned compare, result 32'd1/32'd0.
- Shifts (SLL, SRL, SRA): amount = op_b[4:0]. SRA is arithmetic on signed op_a.
- NOP codes 0 and 15: res = 0.
- is_mul = ALU_op in 11..14.
- Multiplier operands are extended to 33 bits:
  - op_a is sign-extended for MUL, MULH, MULHSU; zero-extended for MULHU.
  - op_b is sign-extended for MUL, MULH; zero-extended for MULHSU, MULHU.
  - A 66-bit signed product is formed.
- Registers (asynchronously reset by nrst): prod[63:0] = 0, done = 0.
- At each rising CLK:
  - load_hazard=1: done <= 0; prod holds.
  - else if is_mul and done=0: prod <= product[63:0], done <= 1.
  - else: done <= 0.
- mul_stall = is_mul AND NOT done (combinational). Stall is therefore exactly one cycle per multiply once load_hazard is low, and persists while load_hazard is high.
- Multiply result:
  - MUL: res = prod[31:0].
  - MULH/MULHSU/MULHU: res = prod[63:32].
  - While mul_stall=1, res contents are don't-care for consumers.
- Back-to-back multiplies (ALU_op held at a mul code across the completion edge): the cycle after done=1 sees done cleared and stalls again, i.e. each pipeline-advanced multiply costs 2 cycles.
- Flags:
  - z = (res == 0).
  - less = (op_a < op_b) unsigned when ALU_op=SLTU, signed otherwise (BLT/BGE use signed, BLTU/BGEU present SLTU).
- During reset: mul_stall = is_mul (done=0); res for mul ops = 0.
- Reset asserted mid-multiply aborts the multiply; the multiply restarts from scratch after release.

Test Plan:
- nrst=1 (reset asserted), ALU_op=MUL → mul_stall=1, res=0. Release reset, hold load_hazard=0 → one edge later mul_stall=0.
- A=C0E19800, B=EEE19000, combinational ops → required results:
  - ADD=AFC32800, SUB=D2000800, AND=C0E19000, OR=EEE19800, XOR=2E000800.
  - SLT=1, SLTU=1, SLL (shift 0)=C0E19800.
  - less=1; z=0 except NOP (z=1).
- Same operands, ALU_op=MUL with load_hazard=1 for one edge → mul_stall stays 1. Drop load_hazard → next edge mul_stall=0, res=7D800000.
- Same operands: MULH → res=04388615; MULHU → res=B3FBAE15; MULHSU → res=C51A1E15. Each shows mul_stall=1 for exactly one cycle after the op change.
- Shifts with A=80000000, B=0000003F (amount 31):
  - SLL=00000000.
  - SRL=00000001.
  - SRA=FFFFFFFF.
  - SLT(A,B)=1, SLTU(A,B)=0; less follows the same (1 for SLT, 0 for SLTU).
- SUB with A=B=12345678 → res=0, z=1. Corner MUL: A=FFFFFFFF, B=FFFFFFFF:
  - MULH=00000000.
  - MULHU=FFFFFFFE.
  - MULHSU=FFFFFFFF.
  - MUL=00000001.
